// File: rtl/rs_alu_bank.sv
// Tomasulo reservation-station bank (NUM_RS stations, age-ordered dispatch) feeding one integer ALU.
// Optional macro RS_ALU_SHIFT_EN enables SLL/SRA on opcodes 010/011.
module rs_alu_bank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TAG_W    = 6,
    parameter int unsigned NUM_RS   = 3,
    parameter int unsigned BASE_TAG = 1,
    parameter int unsigned LATENCY  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              A_invalid,
    input  logic              B_invalid,
    output logic              available,
    output logic [TAG_W-1:0]  RS_available,
    output logic [TAG_W-1:0]  issued,
    output logic              error,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  RS_executing
);
    localparam int unsigned IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int unsigned RANK_W = $clog2(NUM_RS + 1);
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef RS_ALU_SHIFT_EN
    localparam int unsigned SH_W   = $clog2(DATA_W);
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BCAST} state_t;

    state_t              r_state, w_state;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic [NUM_RS-1:0]   r_busy, w_busy;
    logic [2:0]          r_op   [NUM_RS];
    logic [2:0]          w_op   [NUM_RS];
    logic [DATA_W-1:0]   r_vj   [NUM_RS];
    logic [DATA_W-1:0]   w_vj   [NUM_RS];
    logic [DATA_W-1:0]   r_vk   [NUM_RS];
    logic [DATA_W-1:0]   w_vk   [NUM_RS];
    logic [TAG_W-1:0]    r_qj   [NUM_RS];
    logic [TAG_W-1:0]    w_qj   [NUM_RS];
    logic [TAG_W-1:0]    r_qk   [NUM_RS];
    logic [TAG_W-1:0]    w_qk   [NUM_RS];
    logic [RANK_W-1:0]   r_rank [NUM_RS];
    logic [RANK_W-1:0]   w_rank [NUM_RS];
    logic [IDX_W-1:0]    r_exec_idx, w_exec_idx;
    logic                r_available, w_available;
    logic [TAG_W-1:0]    r_rs_avail, w_rs_avail;
    logic [TAG_W-1:0]    r_issued, w_issued;
    logic                r_error, w_error;
    logic                r_cdb_req, w_cdb_req;
    logic [TAG_W-1:0]    r_out_tag, w_out_tag;
    logic [DATA_W-1:0]   r_out_data, w_out_data;
    logic [TAG_W-1:0]    r_rs_exec, w_rs_exec;

    logic                w_grant;
    logic                w_free_found, w_sel_found, w_nxt_found;
    logic [IDX_W-1:0]    w_free_idx, w_sel_idx;
    logic [RANK_W-1:0]   w_busy_cnt, w_sel_rank, w_free_rank;

    function automatic logic [TAG_W-1:0] tag_of(input int idx);
        return TAG_W'(BASE_TAG) + TAG_W'(idx);
    endfunction

    function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
`ifdef RS_ALU_SHIFT_EN
            3'b010:  return a << b[SH_W-1:0];
            3'b011:  return $unsigned($signed(a) >>> b[SH_W-1:0]);
`endif
            3'b100:  return a | b;
            3'b101:  return a & b;
            3'b110:  return ~a;
            3'b111:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Next-state for stations, age ranks and the FU FSM.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_busy      = r_busy;
        w_op        = r_op;
        w_vj        = r_vj;
        w_vk        = r_vk;
        w_qj        = r_qj;
        w_qk        = r_qk;
        w_rank      = r_rank;
        w_exec_idx  = r_exec_idx;
        w_issued    = '0;
        w_error     = 1'b0;
        w_cdb_req   = r_cdb_req;
        w_out_tag   = r_out_tag;
        w_out_data  = r_out_data;
        w_rs_exec   = r_rs_exec;
        w_available = 1'b0;
        w_rs_avail  = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        w_sel_rank   = '0;
        w_nxt_found  = 1'b0;
        w_busy_cnt   = '0;
        w_grant      = (r_state == S_BCAST) && cdb_grant;
        w_free_rank  = r_rank[r_exec_idx];

        for (int i = 0; i < int'(NUM_RS); i++) begin
            w_busy_cnt = w_busy_cnt + RANK_W'(r_busy[i]);
            if (!r_busy[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
            if (r_busy[i] && r_qj[i] == '0 && r_qk[i] == '0 &&
                !(r_rs_exec != '0 && IDX_W'(i) == r_exec_idx) &&
                (!w_sel_found || r_rank[i] < w_sel_rank)) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_rank  = r_rank[i];
            end
            if (r_busy[i]) begin
                if (cdb_valid && cdb_tag != '0 && r_qj[i] == cdb_tag) begin
                    w_vj[i] = cdb_data;
                    w_qj[i] = '0;
                end
                if (cdb_valid && cdb_tag != '0 && r_qk[i] == cdb_tag) begin
                    w_vk[i] = cdb_data;
                    w_qk[i] = '0;
                end
                if (w_grant && r_rank[i] > w_free_rank) begin
                    w_rank[i] = r_rank[i] - RANK_W'(1);
                end
            end
        end

        if (w_grant) begin
            w_busy[r_exec_idx] = 1'b0;
        end

        // New station ranks behind every station that survives this cycle.
        if (issue) begin
            if (w_free_found) begin
                w_busy[w_free_idx] = 1'b1;
                w_op[w_free_idx]   = opcode;
                w_rank[w_free_idx] = w_busy_cnt - RANK_W'(w_grant);
                w_issued           = tag_of(int'(w_free_idx));
                w_vj[w_free_idx]   = A;
                w_qj[w_free_idx]   = '0;
                if (A_invalid) begin
                    w_qj[w_free_idx] = A[TAG_W-1:0];
                    if (cdb_valid && cdb_tag != '0 && cdb_tag == A[TAG_W-1:0]) begin
                        w_vj[w_free_idx] = cdb_data;
                        w_qj[w_free_idx] = '0;
                    end
                end
                w_vk[w_free_idx] = B;
                w_qk[w_free_idx] = '0;
                if (B_invalid) begin
                    w_qk[w_free_idx] = B[TAG_W-1:0];
                    if (cdb_valid && cdb_tag != '0 && cdb_tag == B[TAG_W-1:0]) begin
                        w_vk[w_free_idx] = cdb_data;
                        w_qk[w_free_idx] = '0;
                    end
                end
            end else begin
                w_error = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_sel_found) begin
                    w_exec_idx = w_sel_idx;
                    w_rs_exec  = tag_of(int'(w_sel_idx));
                    w_out_tag  = tag_of(int'(w_sel_idx));
                    w_out_data = alu(r_op[w_sel_idx], r_vj[w_sel_idx], r_vk[w_sel_idx]);
                    w_cnt      = CNT_W'(LATENCY - 1);
                    w_state    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_state   = S_BCAST;
                    w_cdb_req = 1'b1;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_BCAST: begin
                if (cdb_grant) begin
                    w_state   = S_IDLE;
                    w_cdb_req = 1'b0;
                    w_rs_exec = '0;
                end
            end
            default: w_state = S_IDLE;
        endcase

        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (!w_busy[i] && !w_nxt_found) begin
                w_nxt_found = 1'b1;
                w_available = 1'b1;
                w_rs_avail  = tag_of(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= '0;
            for (int i = 0; i < int'(NUM_RS); i++) begin
                r_op[i]   <= '0;
                r_vj[i]   <= '0;
                r_vk[i]   <= '0;
                r_qj[i]   <= '0;
                r_qk[i]   <= '0;
                r_rank[i] <= '0;
            end
            r_exec_idx  <= '0;
            r_available <= 1'b1;
            r_rs_avail  <= TAG_W'(BASE_TAG);
            r_issued    <= '0;
            r_error     <= 1'b0;
            r_cdb_req   <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
            r_rs_exec   <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_busy      <= w_busy;
            r_op        <= w_op;
            r_vj        <= w_vj;
            r_vk        <= w_vk;
            r_qj        <= w_qj;
            r_qk        <= w_qk;
            r_rank      <= w_rank;
            r_exec_idx  <= w_exec_idx;
            r_available <= w_available;
            r_rs_avail  <= w_rs_avail;
            r_issued    <= w_issued;
            r_error     <= w_error;
            r_cdb_req   <= w_cdb_req;
            r_out_tag   <= w_out_tag;
            r_out_data  <= w_out_data;
            r_rs_exec   <= w_rs_exec;
        end
    end

    assign available    = r_available;
    assign RS_available = r_rs_avail;
    assign issued       = r_issued;
    assign error        = r_error;
    assign cdb_req      = r_cdb_req;
    assign out_tag      = r_out_tag;
    assign out_data     = r_out_data;
    assign RS_executing = r_rs_exec;

endmodule

// File: doc/rs_alu_bank.md
Name: rs_alu_bank

Overview:
- Parametrised bank of Tomasulo reservation stations feeding one integer ALU functional unit.
- Accepts issued instructions whose operands are either values or producer tags.
- Snoops the common data bus (CDB) for pending operands and dispatches the oldest ready station.
- Executes over a fixed latency, then requests the CDB and broadcasts its result under its own station tag. It generalises the fixed three-station adder unit to N stations, arbitrary data and tag widths, age-ordered dispatch, and same-cycle CDB bypass at issue.

Parameters:
- DATA_W, 32, operand/result width (signed, two's complement).
- TAG_W, 6, tag width; tag 0 means "value valid, no producer".
- NUM_RS, 3, number of stations (2..8).
- BASE_TAG, 1, tag of station 0; station i has tag BASE_TAG+i (must be nonzero and fit TAG_W).
- LATENCY, 2, execute cycles from dispatch to CDB request (>=1).

Ports:
- clock  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high
- issue  in  1  issue request this cycle
- opcode  in  3  ALU op
- A, B  in  DATA_W  operand value, or tag in low TAG_W bits when the matching invalid bit is set
- A_invalid, B_invalid  in  1  operand is a tag
- available  out  1  at least one station free
- RS_available  out  TAG_W  tag of the station the next issue will use; 0 if full
- issued  out  TAG_W  tag allocated last cycle; 0 otherwise
- error  out  1  issue attempted while full (one-cycle pulse)
- cdb_valid  in  1  CDB carries a result this cycle
- cdb_tag  in  TAG_W  producer tag on the CDB
- cdb_data  in  DATA_W  result on the CDB
- cdb_req  out  1  request-to-send (rts)
- cdb_grant  in  1  arbiter grant (xmit); honoured only while cdb_req is high
- out_tag  out  TAG_W  broadcast tag
- out_data  out  DATA_W  broadcast value
- RS_executing  out  TAG_W  tag of the station in the FU; 0 if idle

Behaviour:
- Reset (async):
  - All stations not busy, all Q fields cleared to 0, age counters 0.
  - FU FSM goes to IDLE.
  - Outputs go to 0: cdb_req, out_tag, out_data, issued, error, RS_executing.
  - available=1 and RS_available=BASE_TAG.
  - Reset mid-broadcast drops cdb_req immediately; the in-flight result is discarded.
- Issue (posedge with issue=1):
  - If a station is free, allocate the lowest-index free station: busy=1, op latched, issued=its tag next cycle, error=0.
  - For each operand: if the invalid bit is 0, set V=value and Q=0; otherwise set Q=operand[TAG_W-1:0].
  - Bypass: if the operand is invalid, cdb_valid=1, and cdb_tag equals the operand tag in the same cycle, capture cdb_data and set Q=0.
  - If full: no state change; error=1 for one cycle and issued=0.
- Snoop (every posedge):
  - Every busy station with Qj or Qk equal to a nonzero cdb_tag while cdb_valid=1 loads cdb_data into V and clears Q.
  - Capture is independent per operand.
  - Only the CDB updates operands; the bank's own broadcast reaches other stations through the external arbiter echoing it on cdb_*.
- Age:
  - Each station holds an issue-order rank.
  - On issue the new station takes rank = count of busy stations.
  - On free, stations with a higher rank decrement.
  - Simultaneous issue and free apply both updates consistently, so ranks stay unique and dense.
- FU FSM:
  - IDLE: at posedge, if any station is busy with Qj=Qk=0 and is not the FU's own, pick the lowest rank, latch its tag, compute the result, go to EXEC with count=LATENCY-1. RS_executing shows the tag from the next cycle.
  - EXEC: decrement count each cycle; when 0 go to BCAST.
  - BCAST: cdb_req=1; out_tag/out_data stay stable until granted.
  - On posedge with cdb_grant=1: free the station, drop cdb_req, go to IDLE. The next dispatch happens at the following posedge at the earliest.
  - Minimum occupancy per op: 1 dispatch + (LATENCY-1) + 1 broadcast + grant.
  - A station in the FU stays busy and cannot be reselected.
- Ops:
  - 000 ADD: Vj+Vk.
  - 001 SUB: Vj-Vk.
  - 100 OR.
  - 101 AND.
  - 110 NOT: ~Vj, Vk ignored.
  - 111 XOR.
  - Results wrap modulo 2^DATA_W.
  - 010/011 produce 0 when the optional feature is absent.

Optional Feature:
- Macro: RS_ALU_SHIFT_EN.
- Defined:
  - 010 = SLL (Vj << Vk[clog2(DATA_W)-1:0]).
  - 011 = SRA (arithmetic Vj >>> the same amount).
- Undefined: 010/011 complete normally with result 0. No shifter logic is present.

Test Plan:
- Issue ADD A=5, B=7, both valid; grant on the first cdb_req -> issued=1 the next cycle; cdb_req rises LATENCY+1 cycles after issue with out_tag=1, out_data=12; station freed and available=1 after the grant.
- Issue four ops with no grants -> tags 1, 2, 3; fourth attempt gives error=1, issued=0, available=0, RS_available=0.
- Issue SUB with A tag 9 (invalid), B=3; then drive cdb_valid, tag 9, data 10 -> capture, dispatch, broadcast out_data=7; also repeat with the CDB driven in the issue cycle -> bypass gives the same result with no extra cycle.
- Issue a station waiting on tag 9, then a later ready station, then deliver tag 9 while the FU is busy -> the older station (rank 0) dispatches first at the next IDLE.
- Hold cdb_grant=0 for 5 cycles in BCAST -> cdb_req, out_tag and out_data remain stable; assert reset mid-BCAST -> cdb_req=0 immediately and all stations free.
- NOT with A=0x0000_00FF -> 0xFFFF_FF00. With RS_ALU_SHIFT_EN, SRA A=0x8000_0000, B=4 -> 0xF800_0000; without it, the same op gives 0.
